// File: rtl/reg_fifo_ab_pkg.sv
// rtl/reg_fifo_ab_pkg.sv - shared state encodings and width default for reg_fifo_ab
package reg_fifo_ab_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [7:0] STATE_RESET = 8'h00;
    localparam logic [7:0] STATE_EMPTY = 8'h01;
    localparam logic [7:0] STATE_HALF  = 8'h02;
    localparam logic [7:0] STATE_FULL  = 8'h03;

    typedef enum logic [7:0] {
        ST_RESET = STATE_RESET,
        ST_EMPTY = STATE_EMPTY,
        ST_HALF  = STATE_HALF,
        ST_FULL  = STATE_FULL
    } state_e;

endpackage

// File: rtl/reg_fifo_ab_slot.sv
// rtl/reg_fifo_ab_slot.sv - one payload register with load enable and async clear
module reg_fifo_slot
    import reg_fifo_ab_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_fifo_ab.sv
// rtl/reg_fifo_ab.sv - two-entry ping-pong register slice FIFO
module reg_fifo_ab
    import reg_fifo_ab_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    input  logic [DATA_WIDTH-1:0] S_WDATA,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA
);

    state_e state_q, state_d;
    logic   mux_in_q, mux_in_d;
    logic   mux_out_q, mux_out_d;

    logic [7:0] state;
    logic       mux_in;
    logic       mux_out;
    logic       push;
    logic       pop;
    logic       wr_in_valid_A;
    logic       wr_in_valid_B;
    logic       wr_out_valid_A;
    logic       wr_out_valid_B;
    logic [DATA_WIDTH-1:0] slot_a;
    logic [DATA_WIDTH-1:0] slot_b;

    assign state   = state_q;
    assign mux_in  = mux_in_q;
    assign mux_out = mux_out_q;

    // Handshake flags are decoded only from the state register, never from inputs.
    assign S_WREADY = (state_q == ST_EMPTY) || (state_q == ST_HALF);
    assign M_WVALID = (state_q == ST_HALF)  || (state_q == ST_FULL);
    assign M_WDATA  = mux_out_q ? slot_b : slot_a;

    assign push = S_WVALID & S_WREADY;
    assign pop  = M_WVALID & M_WREADY;

    assign wr_in_valid_A  = push & ~mux_in_q;
    assign wr_in_valid_B  = push &  mux_in_q;
    assign wr_out_valid_A = pop  & ~mux_out_q;
    assign wr_out_valid_B = pop  &  mux_out_q;

    reg_fifo_slot #(.WIDTH(DATA_WIDTH)) u_slot_a (
        .clk_i  (CLK_I),
        .rst_ni (RST_I),
        .load_i (wr_in_valid_A),
        .d_i    (S_WDATA),
        .q_o    (slot_a)
    );

    reg_fifo_slot #(.WIDTH(DATA_WIDTH)) u_slot_b (
        .clk_i  (CLK_I),
        .rst_ni (RST_I),
        .load_i (wr_in_valid_B),
        .d_i    (S_WDATA),
        .q_o    (slot_b)
    );

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q   <= ST_RESET;
            mux_in_q  <= 1'b0;
            mux_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_in_q  <= mux_in_d;
            mux_out_q <= mux_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mux_in_d  = mux_in_q ^ (wr_in_valid_A | wr_in_valid_B);
        mux_out_d = mux_out_q ^ (wr_out_valid_A | wr_out_valid_B);
        case (state_q)
            ST_RESET: state_d = ST_EMPTY;
            ST_EMPTY: if (push) state_d = ST_HALF;
            ST_HALF: begin
                if (push && !pop) begin
                    state_d = ST_FULL;
                end else if (pop && !push) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL:  if (pop) state_d = ST_HALF;
            default:  state_d = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_reg_fifo_ab.sv
// tb/tb_reg_fifo_ab.sv - scoreboard bench for two chained reg_fifo_ab instances
module tb_reg_fifo_ab;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       mid_valid;
    logic       mid_ready;
    logic [7:0] mid_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;

    int         n_vec = 0;
    int         n_err = 0;
    int         acc_cnt = 0;
    int         pop_cnt = 0;
    logic [7:0] next_byte = 8'h33;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    reg_fifo_ab #(.DATA_WIDTH(8)) u1 (
        .CLK_I    (clk),
        .RST_I    (rst_n),
        .S_WVALID (s_valid),
        .S_WREADY (s_ready),
        .S_WDATA  (s_data),
        .M_WVALID (mid_valid),
        .M_WREADY (mid_ready),
        .M_WDATA  (mid_data)
    );

    reg_fifo_ab #(.DATA_WIDTH(8)) u2 (
        .CLK_I    (clk),
        .RST_I    (rst_n),
        .S_WVALID (mid_valid),
        .S_WREADY (mid_ready),
        .S_WDATA  (mid_data),
        .M_WVALID (m_valid),
        .M_WREADY (m_ready),
        .M_WDATA  (m_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an unbounded ordered queue of every accepted byte; reset empties it.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: got %0h, expected no output", m_data);
                end else begin
                    check("sb_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                acc_cnt++;
                next_byte++;
            end
        end
    end

    task automatic drive(input logic v, input logic r);
        @(posedge clk);
        #1;
        s_valid = v;
        m_ready = r;
        s_data  = v ? next_byte : 8'($urandom);
    endtask

    task automatic end_phase();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int p0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = 8'h00;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_s_wready", {31'h0, s_ready}, 32'h0);
            check("rst_m_wvalid", {31'h0, m_valid}, 32'h0);
            check("rst_m_wdata", {24'h0, m_data}, 32'h0);
        end
        rst_n = 1'b1;
        #1;
        check("rel_pre_edge_s_wready", {31'h0, s_ready}, 32'h0);
        @(negedge clk);
        check("rel_s_wready", {31'h0, s_ready}, 32'h1);
        check("rel_m_wvalid", {31'h0, mid_valid}, 32'h0);
        check("rel_state", {24'h0, u1.state}, 32'h1);

        // Fill with the sink stalled: four words fit in the chain.
        a0 = acc_cnt;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
        end_phase();
        check("fill_accepted", acc_cnt - a0, 4);
        check("fill_s_wready", {31'h0, s_ready}, 32'h0);
        check("fill_state_u1", {24'h0, u1.state}, 32'h3);
        check("fill_state_u2", {24'h0, u2.state}, 32'h3);

        p0 = pop_cnt;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1);
            for (int g = 0; g < 3; g++) drive(1'b1, 1'b0);
        end
        end_phase();
        check("pulse_pops", pop_cnt - p0, 4);
        check("pulse_refill_depth", exp_q.size(), 4);

        p0 = pop_cnt;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1);
        end_phase();
        check("stream_pops", pop_cnt - p0, 20);

        a0 = acc_cnt;
        for (int i = 0; i < 20; i++) drive((i % 2) == 0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1);
        end_phase();
        check("sparse_accepted", acc_cnt - a0, 10);
        check("sparse_drained", exp_q.size(), 0);
        check("sparse_m_wvalid", {31'h0, m_valid}, 32'h0);

        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0);
        end_phase();
        check("mid_fill_u1", {24'h0, u1.state}, 32'h3);
        check("mid_fill_u2", {24'h0, u2.state}, 32'h3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_s_wready", {31'h0, s_ready}, 32'h0);
        check("arst_m_wvalid", {31'h0, m_valid}, 32'h0);
        check("arst_mid_valid", {31'h0, mid_valid}, 32'h0);
        check("arst_m_wdata", {24'h0, m_data}, 32'h0);
        repeat (3) @(negedge clk);
        next_byte = 8'hA5;
        rst_n = 1'b1;
        @(negedge clk);
        check("rerel_state_u2", {24'h0, u2.state}, 32'h1);

        // Single word: one cycle per instance, two through the chain.
        p0 = pop_cnt;
        drive(1'b1, 1'b0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("lat1_mid_valid", {31'h0, mid_valid}, 32'h1);
        check("lat1_m_wvalid", {31'h0, m_valid}, 32'h0);
        @(negedge clk);
        check("lat2_m_wvalid", {31'h0, m_valid}, 32'h1);
        check("lat2_m_wdata", {24'h0, m_data}, 32'hA5);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        end_phase();
        check("post_rst_pops", pop_cnt - p0, 1);
        check("post_rst_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
